// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single processor-memory port between the dcache controller
// (loads and stores) and the icache controller (loads only).
//
// Grant and forwarding are combinational, so memory's same-cycle accept
// response is routed back to the granted requester in the same cycle.
// A 16-entry owner table records which requester owns each accepted load
// tag, so data returning from memory is routed to the right controller.
//
// Optional build macro: MEM_ARB_RR_EN
//   defined   : round-robin on ties (no lock active), using last_grant.
//   undefined : fixed dcache priority on ties.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   dc2arb_command/addr/data     dcache request (NONE / LOAD / STORE)
//   ic2arb_command/addr          icache request (NONE / LOAD; STORE = NONE)
//   mem2arb_response             accept tag for this cycle's command, 0 = rejected
//   mem2arb_tag/data             returning load tag (0 = none) and data
//   arb2mem_command/addr/data    granted command towards memory
//   arb2dc_response/arb2ic_response  accept tag to the granted requester only
//   arb2dc_tag/arb2ic_tag        returning tag routed to its owner
//   arb2dc_data/arb2ic_data      returning data to both, qualified by tags
//   arb_outstanding              registered count of valid owner entries
module mem_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        dc2arb_command,
  input  logic [ADDR_W-1:0] dc2arb_addr,
  input  logic [DATA_W-1:0] dc2arb_data,
  input  logic [1:0]        ic2arb_command,
  input  logic [ADDR_W-1:0] ic2arb_addr,
  input  logic [TAG_W-1:0]  mem2arb_response,
  input  logic [TAG_W-1:0]  mem2arb_tag,
  input  logic [DATA_W-1:0] mem2arb_data,
  output logic [1:0]        arb2mem_command,
  output logic [ADDR_W-1:0] arb2mem_addr,
  output logic [DATA_W-1:0] arb2mem_data,
  output logic [TAG_W-1:0]  arb2dc_response,
  output logic [TAG_W-1:0]  arb2ic_response,
  output logic [TAG_W-1:0]  arb2dc_tag,
  output logic [TAG_W-1:0]  arb2ic_tag,
  output logic [DATA_W-1:0] arb2dc_data,
  output logic [DATA_W-1:0] arb2ic_data,
  output logic [TAG_W:0]    arb_outstanding
);

  localparam int DEPTH = 1 << TAG_W;

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  localparam logic [TAG_W:0]   CNT_MAX  = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ZERO = {(TAG_W+1){1'b0}};
  localparam logic [TAG_W:0]   CNT_ONE  = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [TAG_W-1:0] TAG_NONE = {TAG_W{1'b0}};

  // Request decode and grant
  logic dc_active_s;
  logic ic_active_s;
  logic both_active_s;
  logic tie_dc_s;
  logic grant_dc_s;
  logic grant_ic_s;
  logic accept_s;

  // Lock register: holds the grant for a rejected requester.
  logic lock_valid_r;
  logic lock_dc_r;
  logic lock_hold_s;

  // Owner table
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] is_dc_r;
  logic             alloc_s;
  logic             retire_s;
  logic             retire_dc_s;

  assign dc_active_s   = (dc2arb_command != BUS_NONE);
  assign both_active_s = dc_active_s && ic_active_s;
  assign accept_s      = (mem2arb_response != TAG_NONE);

  // Icache can only load; a store encoding from it is ignored.
  always_comb begin
    case (ic2arb_command)
      BUS_LOAD:  ic_active_s = 1'b1;
      BUS_STORE: ic_active_s = 1'b0;
      default:   ic_active_s = 1'b0;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  logic last_dc_r;

  // The requester that was not accepted last wins the next unlocked tie.
  assign tie_dc_s = !last_dc_r;

  // Remember the last accepted requester; reset value favours dcache first.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_dc_r <= 1'b0;
    end else if ((grant_dc_s || grant_ic_s) && accept_s) begin
      last_dc_r <= grant_dc_s;
    end
  end
`else
  assign tie_dc_s = 1'b1;
`endif

  // Grant selection: single requester, then lock, then tie-break.
  always_comb begin
    grant_dc_s = 1'b0;
    grant_ic_s = 1'b0;
    if (both_active_s) begin
      if (lock_valid_r) begin
        grant_dc_s = lock_dc_r;
        grant_ic_s = !lock_dc_r;
      end else begin
        grant_dc_s = tie_dc_s;
        grant_ic_s = !tie_dc_s;
      end
    end else if (dc_active_s) begin
      grant_dc_s = 1'b1;
    end else if (ic_active_s) begin
      grant_ic_s = 1'b1;
    end else begin
      grant_dc_s = 1'b0;
      grant_ic_s = 1'b0;
    end
  end

  // Forward the granted request to memory and route the accept response back.
  always_comb begin
    arb2mem_command = BUS_NONE;
    arb2mem_addr    = {ADDR_W{1'b0}};
    arb2mem_data    = {DATA_W{1'b0}};
    arb2dc_response = TAG_NONE;
    arb2ic_response = TAG_NONE;
    if (grant_dc_s) begin
      arb2mem_command = dc2arb_command;
      arb2mem_addr    = dc2arb_addr;
      arb2mem_data    = dc2arb_data;
      arb2dc_response = mem2arb_response;
    end else if (grant_ic_s) begin
      arb2mem_command = BUS_LOAD;
      arb2mem_addr    = ic2arb_addr;
      arb2ic_response = mem2arb_response;
    end else begin
      arb2mem_command = BUS_NONE;
    end
  end

  assign alloc_s     = (arb2mem_command == BUS_LOAD) && accept_s;
  assign retire_s    = (mem2arb_tag != TAG_NONE) && valid_r[mem2arb_tag];
  assign retire_dc_s = is_dc_r[mem2arb_tag];

  // Route a returning tag to its recorded owner; orphans go nowhere.
  always_comb begin
    arb2dc_tag = TAG_NONE;
    arb2ic_tag = TAG_NONE;
    if (retire_s) begin
      if (retire_dc_s) begin
        arb2dc_tag = mem2arb_tag;
      end else begin
        arb2ic_tag = mem2arb_tag;
      end
    end else begin
      arb2dc_tag = TAG_NONE;
    end
  end

  assign arb2dc_data = mem2arb_data;
  assign arb2ic_data = mem2arb_data;

  // The lock stays only while the locked requester keeps asking.
  assign lock_hold_s = lock_valid_r && (lock_dc_r ? dc_active_s : ic_active_s);

  // Set or keep the lock on a rejection under contention; clear otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_valid_r <= 1'b0;
      lock_dc_r    <= 1'b0;
    end else if ((grant_dc_s || grant_ic_s) && !accept_s && (both_active_s || lock_hold_s)) begin
      lock_valid_r <= 1'b1;
      lock_dc_r    <= grant_dc_s;
    end else begin
      lock_valid_r <= 1'b0;
      lock_dc_r    <= 1'b0;
    end
  end

  // Owner table: retire clears first so a same-tag allocation wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
      is_dc_r <= {DEPTH{1'b0}};
    end else begin
      if (retire_s) begin
        valid_r[mem2arb_tag] <= 1'b0;
      end
      if (alloc_s) begin
        valid_r[mem2arb_response] <= 1'b1;
        is_dc_r[mem2arb_response] <= grant_dc_s;
      end
    end
  end

  // Outstanding count, saturating at the table depth and floored at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      arb_outstanding <= CNT_ZERO;
    end else begin
      case ({alloc_s, retire_s})
        2'b10: begin
          if (arb_outstanding != CNT_MAX) begin
            arb_outstanding <= arb_outstanding + CNT_ONE;
          end
        end
        2'b01: begin
          if (arb_outstanding != CNT_ZERO) begin
            arb_outstanding <= arb_outstanding - CNT_ONE;
          end
        end
        default: arb_outstanding <= arb_outstanding;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Report memory handing out a tag that is still outstanding.
  always_ff @(posedge clock) begin
    if (!reset && alloc_s && valid_r[mem2arb_response] &&
        !(retire_s && (mem2arb_tag == mem2arb_response))) begin
      $display("mem_bus_arbiter: protocol violation, tag %0d reallocated while outstanding",
               mem2arb_response);
    end
  end
`endif

endmodule
